// File: rtl/mnist_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its host / classifier core.
// The slave modport is the sequencer's view; master is the driver's view.
interface mnist_frame_sequencer_if;
    logic       start;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] core_byte;
    logic       frame_sync;
    logic [3:0] core_index;
    logic [7:0] core_value;
    logic       busy;
    logic       result_valid;
    logic [3:0] result_index;
    logic [7:0] result_value;
    logic       wr_drop;

    modport master (
        output start, wr_en, wr_addr, wr_data, core_index, core_value,
        input  core_byte, frame_sync, busy, result_valid, result_index,
               result_value, wr_drop
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_data, core_index, core_value,
        output core_byte, frame_sync, busy, result_valid, result_index,
               result_value, wr_drop
    );
endinterface

// File: rtl/mnist_frame_sequencer.sv
// Buffers one image frame, streams it byte-by-byte into the classifier and latches its result.
// Define AUTO_RESTART_EN to restream the buffer continuously after the first start.
module mnist_frame_sequencer #(
    parameter int FRAME_BYTES = 32,
    parameter int LATENCY     = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    mnist_frame_sequencer_if.slave bus
);

    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

`ifdef AUTO_RESTART_EN
    localparam bit AUTO_RESTART = 1'b1;
`else
    localparam bit AUTO_RESTART = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [7:0]       r_buf [FRAME_BYTES];

    logic             w_last_byte;
    logic             w_lat_done;
    logic             w_capture;
    logic             w_wr_ok;
    logic             w_wr_reject;
    logic             w_busy;
    logic             w_frame_sync;
    logic [7:0]       w_core_byte;

    logic             r_result_valid;
    logic [3:0]       r_result_index;
    logic [7:0]       r_result_value;
    logic             r_wr_drop;

    assign w_last_byte = (r_state == S_STREAM) && (r_byte_cnt == LAST_BYTE);
    assign w_lat_done  = (r_state == S_WAIT) && (r_lat_cnt == LAST_LAT);
    // With no latency the core result is already valid on the last streamed byte.
    assign w_capture   = (LATENCY == 0) ? w_last_byte : w_lat_done;

    assign w_wr_ok     = bus.wr_en && !w_busy && (int'(bus.wr_addr) < FRAME_BYTES);
    assign w_wr_reject = bus.wr_en && !w_wr_ok;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_byte) begin
                    if (LATENCY > 0)       w_next_state = S_WAIT;
                    else if (AUTO_RESTART) w_next_state = S_STREAM;
                    else                   w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (w_lat_done) w_next_state = AUTO_RESTART ? S_STREAM : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_frame_sync = (r_state == S_STREAM) && (r_byte_cnt == '0);
        w_core_byte  = (r_state == S_STREAM) ? r_buf[r_byte_cnt] : 8'd0;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_lat_cnt  <= '0;
        end else begin
            r_byte_cnt <= (r_state == S_STREAM && !w_last_byte) ? r_byte_cnt + 1'b1 : '0;
            r_lat_cnt  <= (r_state == S_WAIT && !w_lat_done) ? r_lat_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_result_valid <= 1'b0;
            r_result_index <= 4'd0;
            r_result_value <= 8'd0;
            r_wr_drop      <= 1'b0;
        end else begin
            r_result_valid <= w_capture;
            r_wr_drop      <= w_wr_reject;
            if (w_capture) begin
                r_result_index <= bus.core_index;
                r_result_value <= bus.core_value;
            end
        end
    end

    // NOTE: the frame buffer has no reset; its contents must survive an aborted frame.
    always_ff @(posedge CLK) begin
        if (w_wr_ok) r_buf[bus.wr_addr[CNT_W-1:0]] <= bus.wr_data;
    end

    assign bus.busy         = w_busy;
    assign bus.frame_sync   = w_frame_sync;
    assign bus.core_byte    = w_core_byte;
    assign bus.result_valid = r_result_valid;
    assign bus.result_index = r_result_index;
    assign bus.result_value = r_result_value;
    assign bus.wr_drop      = r_wr_drop;

endmodule

// File: tb/tb_mnist_frame_sequencer.sv
// Directed-random bench for mnist_frame_sequencer against a cycle-indexed frame model.
// Honours AUTO_RESTART_EN when the design is built with it.
module tb_mnist_frame_sequencer;

    localparam int FB = 32;
    localparam int LAT = 2;
    localparam int P = FB + LAT;
`ifdef AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic rst;

    mnist_frame_sequencer_if bus ();

    mnist_frame_sequencer #(
        .FRAME_BYTES(FB),
        .LATENCY    (LAT)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_buf [FB];
    logic [3:0] exp_idx;
    logic [7:0] exp_val;
    bit         fix_core;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (!fix_core) begin
            bus.core_index = 4'($urandom);
            bus.core_value = 8'($urandom);
        end
    endtask

    task automatic write_byte(input int addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
        model_buf[addr] = data;
        check("idle_write_drop", 32'(bus.wr_drop), 32'd0);
    endtask

    // Start a frame in the current cycle t and check every output cycle by cycle.
    task automatic do_frame(input int stray_k, input int drop_k, input int abort_k,
                            input int same_wr_addr);
        int         n_cyc;
        int         phase;
        bit         active;
        bit         valid_exp;
        logic [7:0] exp_byte;
        logic [7:0] d;
        logic [3:0] cap_idx;
        logic [7:0] cap_val;
        n_cyc   = AUTO ? 2 * P + 2 : P + 2;
        cap_idx = 4'd0;
        cap_val = 8'd0;
        bus.start = 1'b1;
        if (same_wr_addr >= 0) begin
            d = 8'($urandom);
            bus.wr_en   = 1'b1;
            bus.wr_addr = 5'(same_wr_addr);
            bus.wr_data = d;
            model_buf[same_wr_addr] = d;
        end
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            if (c == abort_k) begin
                rst = 1'b1;
                #1;
                exp_idx = 4'd0;
                exp_val = 8'd0;
                check("abort_core_byte", 32'(bus.core_byte), 32'd0);
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_frame_sync", 32'(bus.frame_sync), 32'd0);
                check("abort_result_index", 32'(bus.result_index), 32'(exp_idx));
                tick();
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    check("post_abort_busy", 32'(bus.busy), 32'd0);
                    check("post_abort_valid", 32'(bus.result_valid), 32'd0);
                    tick();
                end
                return;
            end
            active    = AUTO ? 1'b1 : (c <= P);
            phase     = AUTO ? (c - 1) % P : c - 1;
            exp_byte  = (active && phase < FB) ? model_buf[phase] : 8'd0;
            valid_exp = (c > 1) && ((c - 1) % P == 0);
            if (valid_exp) begin
                exp_idx = cap_idx;
                exp_val = cap_val;
            end
            check("core_byte", 32'(bus.core_byte), 32'(exp_byte));
            check("frame_sync", 32'(bus.frame_sync), 32'(active && phase == 0));
            check("busy", 32'(bus.busy), 32'(active));
            check("result_valid", 32'(bus.result_valid), 32'(valid_exp));
            check("result_index", 32'(bus.result_index), 32'(exp_idx));
            check("result_value", 32'(bus.result_value), 32'(exp_val));
            check("busy_write_drop", 32'(bus.wr_drop), 32'(drop_k > 0 && c == drop_k + 1));
            // The classifier output present in cycle t+P is what the edge ending it captures.
            if (c % P == 0) begin
                cap_idx = bus.core_index;
                cap_val = bus.core_value;
            end
            bus.start = (c == stray_k);
            if (c == drop_k) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 5'd3;
                bus.wr_data = ~model_buf[3];
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (AUTO) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_idx = 4'd0;
            exp_val = 8'd0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        fix_core       = 1'b1;
        bus.start      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 5'd0;
        bus.wr_data    = 8'd0;
        bus.core_index = 4'd5;
        bus.core_value = 8'hA3;
        exp_idx        = 4'd0;
        exp_val        = 8'd0;
        tick();
        tick();
        check("rst_core_byte", 32'(bus.core_byte), 32'd0);
        check("rst_frame_sync", 32'(bus.frame_sync), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result_index", 32'(bus.result_index), 32'd0);
        check("rst_result_value", 32'(bus.result_value), 32'd0);
        check("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Ramp image, fixed classifier output 5 / 0xA3.
        for (int k = 0; k < FB; k++) write_byte(k, 8'(k + 1));
        do_frame(-1, -1, -1, -1);

        // Randomised core output; stray start at t+5 and rejected write to byte 3 at t+10.
        fix_core = 1'b0;
        do_frame(5, 10, -1, -1);
        do_frame(-1, -1, -1, -1);

        // Random partial reload, then abort mid-stream.
        for (int i = 0; i < 8; i++) write_byte(int'($urandom_range(FB - 1, 0)), 8'($urandom));
        do_frame(-1, -1, 20, -1);

        // Intact buffer after abort, with a write landing in the same cycle as start.
        do_frame(-1, -1, -1, int'($urandom_range(FB - 1, 0)));
        do_frame(-1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
